wakeup_array: RTL

WAKEUP_ARRAY -- requirements
Module: wakeup_array

---
 rtl/wakeup_array.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/wakeup_array.sv
// wakeup_array - reservation-station wakeup matrix.
//
// Each entry holds two source tags with ready bits. Destination-tag
// broadcasts wake matching sources. An entry requests issue once it is
// valid and both sources are usable.
//
// Optional feature, enabled by defining WAKEUP_DELAYED_WAKEUP_EN:
//   a broadcast carries a latency. A woken source counts down from that
//   latency before it is usable. When several ports match in the same
//   cycle, the minimum latency wins. With the macro undefined, bcast_lat
//   is ignored and no countdown storage exists.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   alloc_*             dispatch writes one entry (index, two tags, ready bits)
//   grant_valid/index   select stage issued an entry (clears its valid bit)
//   bcast_valid/tag/lat NUM_BCAST tag broadcast ports, port k at slice k
//   flush               discard all entries
//   request_vector      per-entry issue request (registered-state only)
//   entry_valid         per-entry occupancy
//   free_count          number of unoccupied entries
//   alloc_err           sticky: allocation targeted an occupied entry
module wakeup_array #(
  parameter int RS_ENTRIES = 8,
  parameter int PREG_W     = 6,
  parameter int NUM_BCAST  = 2,
  parameter int LAT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  input  logic [$clog2(RS_ENTRIES)-1:0] alloc_index,
  input  logic [PREG_W-1:0]             alloc_src1_tag,
  input  logic [PREG_W-1:0]             alloc_src2_tag,
  input  logic                          alloc_src1_rdy,
  input  logic                          alloc_src2_rdy,
  input  logic                          grant_valid,
  input  logic [$clog2(RS_ENTRIES)-1:0] grant_index,
  input  logic [NUM_BCAST-1:0]          bcast_valid,
  input  logic [NUM_BCAST*PREG_W-1:0]   bcast_tag,
  input  logic [NUM_BCAST*LAT_W-1:0]    bcast_lat,
  input  logic                          flush,
  output logic [RS_ENTRIES-1:0]         request_vector,
  output logic [RS_ENTRIES-1:0]         entry_valid,
  output logic [$clog2(RS_ENTRIES):0]   free_count,
  output logic                          alloc_err
);

  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0] r_valid;
  logic [RS_ENTRIES-1:0] r_rdy1;
  logic [RS_ENTRIES-1:0] r_rdy2;
  logic [PREG_W-1:0]     r_tag1 [RS_ENTRIES];
  logic [PREG_W-1:0]     r_tag2 [RS_ENTRIES];
  logic                  r_alloc_err;

  logic [RS_ENTRIES-1:0] w_hit1;
  logic [RS_ENTRIES-1:0] w_hit2;
  logic                  w_ahit1;
  logic                  w_ahit2;
  logic                  w_ardy1;
  logic                  w_ardy2;
  logic                  w_alloc_we;
  logic                  w_alloc_err_set;
  logic [RS_ENTRIES-1:0] w_cnt_zero;
  logic [IDX_W:0]        w_occ;

  // True when any strobed broadcast port carries this tag.
  function automatic logic f_hit(
    input logic [PREG_W-1:0]           tag,
    input logic [NUM_BCAST-1:0]        v,
    input logic [NUM_BCAST*PREG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_BCAST; k++) begin
      if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

`ifdef WAKEUP_DELAYED_WAKEUP_EN
  logic [LAT_W-1:0] r_cnt1 [RS_ENTRIES];
  logic [LAT_W-1:0] r_cnt2 [RS_ENTRIES];
  logic [LAT_W-1:0] w_lat1 [RS_ENTRIES];
  logic [LAT_W-1:0] w_lat2 [RS_ENTRIES];
  logic [LAT_W-1:0] w_acnt1;
  logic [LAT_W-1:0] w_acnt2;

  // Smallest latency among matching ports; meaningful only on a hit.
  function automatic logic [LAT_W-1:0] f_min_lat(
    input logic [PREG_W-1:0]           tag,
    input logic [NUM_BCAST-1:0]        v,
    input logic [NUM_BCAST*PREG_W-1:0] tags,
    input logic [NUM_BCAST*LAT_W-1:0]  lats
  );
    logic [LAT_W-1:0] m;
    m = '1;
    for (int unsigned k = 0; k < NUM_BCAST; k++) begin
      if (v[k] && (tags[k*PREG_W +: PREG_W] == tag) &&
          (lats[k*LAT_W +: LAT_W] < m))
        m = lats[k*LAT_W +: LAT_W];
    end
    return m;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      w_lat1[i]     = f_min_lat(r_tag1[i], bcast_valid, bcast_tag, bcast_lat);
      w_lat2[i]     = f_min_lat(r_tag2[i], bcast_valid, bcast_tag, bcast_lat);
      w_cnt_zero[i] = (r_cnt1[i] == '0) && (r_cnt2[i] == '0);
    end
    // A source already ready at dispatch never waits on a countdown.
    w_acnt1 = '0;
    w_acnt2 = '0;
    if (!alloc_src1_rdy && (alloc_src1_tag != '0) && w_ahit1)
      w_acnt1 = f_min_lat(alloc_src1_tag, bcast_valid, bcast_tag, bcast_lat);
    if (!alloc_src2_rdy && (alloc_src2_tag != '0) && w_ahit2)
      w_acnt2 = f_min_lat(alloc_src2_tag, bcast_valid, bcast_tag, bcast_lat);
  end
`else
  logic w_unused_lat;
  assign w_unused_lat = ^bcast_lat;
  assign w_cnt_zero   = '1;
`endif

  always_comb begin
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      w_hit1[i] = f_hit(r_tag1[i], bcast_valid, bcast_tag);
      w_hit2[i] = f_hit(r_tag2[i], bcast_valid, bcast_tag);
    end
    w_ahit1 = f_hit(alloc_src1_tag, bcast_valid, bcast_tag);
    w_ahit2 = f_hit(alloc_src2_tag, bcast_valid, bcast_tag);
    // Same-cycle broadcast is folded into the written ready bit (bypass).
    w_ardy1 = alloc_src1_rdy | (alloc_src1_tag == '0) | w_ahit1;
    w_ardy2 = alloc_src2_rdy | (alloc_src2_tag == '0) | w_ahit2;
    // An entry freed by a grant in this cycle may be refilled at once.
    w_alloc_we = alloc_valid &
                 (~r_valid[alloc_index] | (grant_valid & (grant_index == alloc_index)));
    w_alloc_err_set = alloc_valid & ~w_alloc_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_rdy1      <= '0;
      r_rdy2      <= '0;
      r_alloc_err <= 1'b0;
`ifdef WAKEUP_DELAYED_WAKEUP_EN
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        r_cnt1[i] <= '0;
        r_cnt2[i] <= '0;
      end
`endif
    end else if (flush) begin
      r_valid <= '0;
`ifdef WAKEUP_DELAYED_WAKEUP_EN
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        r_cnt1[i] <= '0;
        r_cnt2[i] <= '0;
      end
`endif
    end else begin
      if (w_alloc_err_set) r_alloc_err <= 1'b1;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        if (w_alloc_we && (alloc_index == IDX_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_tag1[i]  <= alloc_src1_tag;
          r_tag2[i]  <= alloc_src2_tag;
          r_rdy1[i]  <= w_ardy1;
          r_rdy2[i]  <= w_ardy2;
`ifdef WAKEUP_DELAYED_WAKEUP_EN
          r_cnt1[i]  <= w_acnt1;
          r_cnt2[i]  <= w_acnt2;
`endif
        end else begin
          if (grant_valid && (grant_index == IDX_W'(i))) r_valid[i] <= 1'b0;
          // Only not-yet-ready sources wake; a running countdown is never restarted.
`ifdef WAKEUP_DELAYED_WAKEUP_EN
          if (!r_rdy1[i] && w_hit1[i]) begin
            r_rdy1[i] <= 1'b1;
            r_cnt1[i] <= w_lat1[i];
          end else if (r_cnt1[i] != '0) begin
            r_cnt1[i] <= r_cnt1[i] - LAT_W'(1);
          end
          if (!r_rdy2[i] && w_hit2[i]) begin
            r_rdy2[i] <= 1'b1;
            r_cnt2[i] <= w_lat2[i];
          end else if (r_cnt2[i] != '0) begin
            r_cnt2[i] <= r_cnt2[i] - LAT_W'(1);
          end
`else
          if (!r_rdy1[i] && w_hit1[i]) r_rdy1[i] <= 1'b1;
          if (!r_rdy2[i] && w_hit2[i]) r_rdy2[i] <= 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      w_occ = w_occ + (IDX_W+1)'(r_valid[i]);
    end
    free_count = (IDX_W+1)'(RS_ENTRIES) - w_occ;
  end

  assign request_vector = r_valid & r_rdy1 & r_rdy2 & w_cnt_zero;
  assign entry_valid    = r_valid;
  assign alloc_err      = r_alloc_err;

endmodule
